// File: rtl/fu_pkg.sv
// Shared opcodes, shift operations and FSM states for the sequential function unit.
package fu_pkg;

    localparam logic [3:0] OP_TSA   = 4'b0000;
    localparam logic [3:0] OP_INC   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_ADDC  = 4'b0011;
    localparam logic [3:0] OP_ADDNB = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_DEC   = 4'b0110;
    localparam logic [3:0] OP_TSA1  = 4'b0111;

    localparam logic [2:0] LOG_AND = 3'b100;
    localparam logic [2:0] LOG_OR  = 3'b101;
    localparam logic [2:0] LOG_XOR = 3'b110;
    localparam logic [2:0] LOG_NOT = 3'b111;

    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_SHL  = 2'b01,
        SH_SHR  = 2'b10,
        SH_ASR  = 2'b11
    } sh_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fu_state_e;

endpackage

// File: rtl/fu_alu_comb.sv
// Combinational ALU: {s_alu,cin} selects transfer/arithmetic/logic; produces result, V and C.
module fu_alu_comb
    import fu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       s_alu,
    input  logic             cin,
    output logic [WIDTH-1:0] g,
    output logic             v,
    output logic             c
);

    logic [3:0]     op;
    logic [WIDTH:0] opnd_b;
    logic           carry_in;
    logic           arith;
    logic [WIDTH:0] sum;

    assign op = {s_alu, cin};

    // A-1 adds an all-ones (WIDTH+1)-bit operand so that A=0 reports C=1
    always_comb begin
        opnd_b   = '0;
        carry_in = 1'b0;
        arith    = 1'b0;
        case (op)
            OP_INC:   begin arith = 1'b1; carry_in = 1'b1; end
            OP_ADD:   begin arith = 1'b1; opnd_b = {1'b0, b}; end
            OP_ADDC:  begin arith = 1'b1; opnd_b = {1'b0, b}; carry_in = 1'b1; end
            OP_ADDNB: begin arith = 1'b1; opnd_b = {1'b0, ~b}; end
            OP_SUB:   begin arith = 1'b1; opnd_b = {1'b0, ~b}; carry_in = 1'b1; end
            OP_DEC:   begin arith = 1'b1; opnd_b = '1; end
            default:  ;
        endcase
    end

    assign sum = {1'b0, a} + opnd_b + {{WIDTH{1'b0}}, carry_in};

    always_comb begin
        g = a;
        v = 1'b0;
        c = 1'b0;
        if (arith) begin
            g = sum[WIDTH-1:0];
            c = sum[WIDTH];
            v = (a[WIDTH-1] == opnd_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end else begin
            case (s_alu)
                LOG_AND: g = a & b;
                LOG_OR:  g = a | b;
                LOG_XOR: g = a ^ b;
                LOG_NOT: g = ~a;
                default: g = a;
            endcase
        end
    end

endmodule

// File: rtl/function_unit_seq.sv
// Handshaked function unit: registered ALU path plus a one-bit-per-cycle shifter,
// result and flags held until the consumer takes them.
module function_unit_seq
    import fu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic               MODE_SEL,
    input  logic [2:0]         S_ALU,
    input  logic [1:0]         S_SH,
    input  logic [SHAMT_W-1:0] SHAMT,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               CIN,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [WIDTH-1:0]   G,
    output logic               V,
    output logic               C,
    output logic               N,
    output logic               Z
);

    fu_state_e          state, state_nxt;
    logic               accept, start_shift, last_shift, res_load;
    logic [WIDTH-1:0]   alu_g, res_g;
    logic               alu_v, alu_c, res_v, res_c;
    logic [WIDTH-1:0]   sh_val_p0;
    logic [SHAMT_W-1:0] sh_cnt_p0;
    sh_op_e             sh_op_p0;
    logic [WIDTH:0]     sh_step;
    logic [WIDTH-1:0]   g_p1;
    logic               v_p1, c_p1, n_p1, z_p1;

    // Returns {bit shifted out, shifted value}
    function automatic logic [WIDTH:0] shift_step(input sh_op_e op, input logic [WIDTH-1:0] x);
        case (op)
            SH_SHL:  return {x[WIDTH-1], x[WIDTH-2:0], 1'b0};
            SH_SHR:  return {x[0], 1'b0, x[WIDTH-1:1]};
            SH_ASR:  return {x[0], x[WIDTH-1], x[WIDTH-1:1]};
            default: return {1'b0, x};
        endcase
    endfunction

    fu_alu_comb #(.WIDTH(WIDTH)) u_alu (
        .a     (A),
        .b     (B),
        .s_alu (S_ALU),
        .cin   (CIN),
        .g     (alu_g),
        .v     (alu_v),
        .c     (alu_c)
    );

    assign IN_READY    = !RST && ((state == IDLE) || ((state == DONE) && OUT_READY));
    assign accept      = IN_VALID && IN_READY;
    assign start_shift = MODE_SEL && (SHAMT != '0);
    assign last_shift  = (state == SHIFT) && (sh_cnt_p0 == SHAMT_W'(1));
    assign sh_step     = shift_step(sh_op_p0, sh_val_p0);

    always_comb begin
        state_nxt = state;
        res_load  = 1'b0;
        res_g     = alu_g;
        res_v     = alu_v;
        res_c     = alu_c;
        case (state)
            IDLE:    if (accept) state_nxt = start_shift ? SHIFT : DONE;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE: begin
                if (accept)         state_nxt = start_shift ? SHIFT : DONE;
                else if (OUT_READY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (accept && !start_shift) begin
            res_load = 1'b1;
            if (MODE_SEL) begin
                res_g = B;
                res_v = 1'b0;
                res_c = 1'b0;
            end
        end else if (last_shift) begin
            res_load = 1'b1;
            res_g    = sh_step[WIDTH-1:0];
            res_c    = sh_step[WIDTH];
            res_v    = 1'b0;
        end
    end

    // p0: operand capture and iterative shift
    always_ff @(posedge CLK) begin
        if (accept) begin
            sh_val_p0 <= B;
            sh_cnt_p0 <= SHAMT;
            sh_op_p0  <= sh_op_e'(S_SH);
        end else if (state == SHIFT) begin
            sh_val_p0 <= sh_step[WIDTH-1:0];
            sh_cnt_p0 <= sh_cnt_p0 - 1'b1;
        end
    end

    // p1: held result and flags; reset discards any in-flight or pending result
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            g_p1  <= '0;
            v_p1  <= 1'b0;
            c_p1  <= 1'b0;
            n_p1  <= 1'b0;
            z_p1  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (res_load) begin
                g_p1 <= res_g;
                v_p1 <= res_v;
                c_p1 <= res_c;
                n_p1 <= res_g[WIDTH-1];
                z_p1 <= (res_g == '0);
            end
        end
    end

    assign OUT_VALID = (state == DONE);
    assign G         = g_p1;
    assign V         = v_p1;
    assign C         = c_p1;
    assign N         = n_p1;
    assign Z         = z_p1;

endmodule

// File: tb/tb_function_unit_seq.sv
// Bench for function_unit_seq: directed scenarios plus random ops against an arithmetic model.
module tb_function_unit_seq;

    localparam int W  = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          mode_sel;
    logic [2:0]    s_alu;
    logic [1:0]    s_sh;
    logic [SW-1:0] shamt;
    logic [W-1:0]  a, b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  g;
    logic          v, c, n, z;

    int vectors     = 0;
    int miscompares = 0;
    int last_lat    = 0;

    always #5 clk = ~clk;

    function_unit_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .CLK       (clk),
        .RST       (rst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .MODE_SEL  (mode_sel),
        .S_ALU     (s_alu),
        .S_SH      (s_sh),
        .SHAMT     (shamt),
        .A         (a),
        .B         (b),
        .CIN       (cin),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .G         (g),
        .V         (v),
        .C         (c),
        .N         (n),
        .Z         (z)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic, C/V derived from the mathematical result
    function automatic void model(input bit m, input logic [2:0] sa_, input bit ci,
                                  input logic [1:0] sh, input int am,
                                  input logic [W-1:0] aa, input logic [W-1:0] bb,
                                  output logic [W-1:0] eg, output bit ev, output bit ec,
                                  output int lat);
        int ua, ub, sa, sb, ut, st, mask;
        bit arith;
        logic [3:0] op;
        mask = (1 << W) - 1;
        eg = aa; ev = 1'b0; ec = 1'b0; lat = 1;
        if (m) begin
            lat = am + 1;
            case (sh)
                2'b01: begin eg = bb << am; ec = (am > 0) ? bb[W-am] : 1'b0; end
                2'b10: begin eg = bb >> am; ec = (am > 0) ? bb[am-1] : 1'b0; end
                2'b11: begin eg = $signed(bb) >>> am; ec = (am > 0) ? bb[am-1] : 1'b0; end
                default: eg = bb;
            endcase
        end else begin
            op = {sa_, ci};
            ua = int'(aa); ub = int'(bb);
            sa = $signed(aa); sb = $signed(bb);
            arith = 1'b1; ut = 0; st = 0;
            case (op)
                4'b0001: begin ut = ua + 1;               st = sa + 1;      end
                4'b0010: begin ut = ua + ub;              st = sa + sb;     end
                4'b0011: begin ut = ua + ub + 1;          st = sa + sb + 1; end
                4'b0100: begin ut = ua + (mask - ub);     st = sa - sb - 1; end
                4'b0101: begin ut = ua + (mask - ub) + 1; st = sa - sb;     end
                4'b0110: begin ut = ua - 1;               st = sa - 1;      end
                default: arith = 1'b0;
            endcase
            if (arith) begin
                eg = ut[W-1:0];
                ec = (op == 4'b0110) ? (ua == 0) : ut[W];
                ev = (st > (mask >> 1)) || (st < -((mask >> 1) + 1));
            end else begin
                case (sa_)
                    3'b100:  eg = aa & bb;
                    3'b101:  eg = aa | bb;
                    3'b110:  eg = aa ^ bb;
                    3'b111:  eg = ~aa;
                    default: eg = aa;
                endcase
            end
        end
    endfunction

    task automatic do_op(input bit m, input logic [2:0] sa_, input bit ci, input logic [1:0] sh,
                         input int am, input logic [W-1:0] aa, input logic [W-1:0] bb);
        logic [W-1:0] eg;
        bit ev, ec;
        int lat, cyc;
        model(m, sa_, ci, sh, am, aa, bb, eg, ev, ec, lat);
        mode_sel = m; s_alu = sa_; cin = ci; s_sh = sh; shamt = SW'(am); a = aa; b = bb;
        in_valid = 1'b1;
        check("op_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); shamt = SW'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
        end
        last_lat = cyc;
        check("op_latency", cyc, lat);
        check("op_out_valid", out_valid, 1);
        check("op_g", g, eg);
        check("op_v", v, ev);
        check("op_c", c, ec);
        check("op_n", n, eg[W-1]);
        check("op_z", z, (eg == '0));
    endtask

    task automatic ack();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("ack_out_valid", out_valid, 0);
    endtask

    initial begin
        logic [W-1:0] hold_g, eg, qg[8];
        bit hold_v, hold_c, ev, ec, qv[8], qc[8];
        int lat, seen;
        logic [2:0] rs;
        bit rc;

        rst = 1'b1; in_valid = 1'b0; mode_sel = 1'b0; s_alu = '0; s_sh = '0; shamt = '0;
        a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        rst = 1'b0;
        #1;
        check("rst_g", g, 0);
        check("rst_flags", {v, c, n, z}, 4'b0000);
        check("post_rst_in_ready", in_ready, 1);

        do_op(1'b0, 3'b000, 1'b1, 2'b00, 0, 16'h7FFF, 16'h0000);
        check("inc_g", g, 16'h8000);
        check("inc_vncz", {v, n, c, z}, 4'b1100);
        ack();

        do_op(1'b0, 3'b010, 1'b1, 2'b00, 0, 16'h0005, 16'h0005);
        check("sub_g", g, 16'h0000);
        check("sub_zcv", {z, c, v}, 3'b110);
        ack();

        do_op(1'b0, 3'b011, 1'b0, 2'b00, 0, 16'h0000, 16'h1234);
        check("dec_g", g, 16'hFFFF);
        check("dec_c", c, 1);
        ack();

        do_op(1'b1, 3'b000, 1'b0, 2'b11, 3, 16'h0000, 16'h8001);
        check("asr_lat", last_lat, 4);
        check("asr_g", g, 16'hF000);
        check("asr_cn", {c, n}, 2'b01);
        ack();

        do_op(1'b1, 3'b000, 1'b0, 2'b01, 1, 16'h0000, 16'hC000);
        check("shl_lat", last_lat, 2);
        check("shl_g", g, 16'h8000);
        check("shl_c", c, 1);
        ack();

        // Stalled consumer: result must hold while new requests are refused
        do_op(1'b0, 3'b001, 1'b0, 2'b00, 0, 16'h1234, 16'h4321);
        hold_g = g; hold_v = v; hold_c = c;
        in_valid = 1'b1; mode_sel = 1'b0; s_alu = 3'b110; cin = 1'b0;
        a = 16'hA5A5; b = 16'h0FF0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_out_valid", out_valid, 1);
            check("hold_g", g, hold_g);
            check("hold_vc", {v, c}, {hold_v, hold_c});
            check("hold_in_ready", in_ready, 0);
        end
        model(1'b0, 3'b110, 1'b0, 2'b00, 0, 16'hA5A5, 16'h0FF0, eg, ev, ec, lat);
        out_ready = 1'b1;
        #1;
        check("chain_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("chain_out_valid", out_valid, 1);
        check("chain_g", g, eg);
        ack();

        // Reset in the middle of a long shift
        mode_sel = 1'b1; s_sh = 2'b10; shamt = 4'd10; b = 16'hFFFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        check("abort_out_valid", out_valid, 0);
        check("abort_g", g, 0);
        check("abort_in_ready", in_ready, 0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 0);
        check("abort_idle_ready", in_ready, 1);

        // Eight back-to-back ALU ops with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rs = 3'($urandom); rc = 1'($urandom);
            mode_sel = 1'b0; s_alu = rs; cin = rc;
            a = W'($urandom); b = W'($urandom);
            model(1'b0, rs, rc, 2'b00, 0, a, b, qg[i], qv[i], qc[i], lat);
            in_valid = 1'b1;
            #1;
            if (i > 0) begin
                check("b2b_out_valid", out_valid, 1);
                check("b2b_g", g, qg[i-1]);
                check("b2b_vc", {v, c}, {qv[i-1], qc[i-1]});
            end
            check("b2b_in_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        check("b2b_last_valid", out_valid, 1);
        check("b2b_last_g", g, qg[7]);
        check("b2b_last_vc", {v, c}, {qv[7], qc[7]});
        step();
        check("b2b_drain", out_valid, 0);
        out_ready = 1'b0;

        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom), 3'($urandom), 1'($urandom), 2'($urandom),
                  int'($urandom_range(0, W - 1)), W'($urandom), W'($urandom));
            ack();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
